// File: rtl/nested_loop_counter_pkg.sv
// Shared definitions for the convolution loop counters and address generators.
// Holds the FSM encoding, wrap-mode constants and default geometry.
package cnn_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_WRAP    = 1'b1;

    localparam int DEF_NUM_LEVELS = 3;
    localparam int DEF_WIDTH      = 4;

endpackage

// File: rtl/counter_stage.sv
// One level of the nested loop counter: counts 0..limit on carry_in,
// wrapping to 0 when a carry arrives while already at the limit.
module counter_stage #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] limit,
    input  logic             carry_in,
    input  logic             clear,
    output logic [WIDTH-1:0] value,
    output logic             at_limit
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    assign at_limit = (value_q == limit);
    assign value    = value_q;

    always_comb begin
        value_d = value_q;
        if (clear) begin
            value_d = '0;
        end else if (carry_in) begin
            value_d = at_limit ? '0 : value_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/nested_loop_counter.sv
// Cascaded loop-index generator with start/busy/done handshake, stall
// and one-shot or free-running wrap modes. Level 0 is the innermost loop.
module nested_loop_counter
    import cnn_counter_pkg::*;
#(
    parameter int NUM_LEVELS = DEF_NUM_LEVELS,
    parameter int WIDTH      = DEF_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        enable,
    input  logic                        abort,
    input  logic                        cfg_mode,
    input  logic [NUM_LEVELS*WIDTH-1:0] cfg_limit,
    output logic [NUM_LEVELS*WIDTH-1:0] count_out,
    output logic                        valid,
    output logic [NUM_LEVELS-1:0]       level_wrap,
    output logic                        busy,
    output logic                        done
);

    state_e                        state_q, state_d;
    logic [NUM_LEVELS*WIDTH-1:0]   limit_q, limit_d;
    logic                          mode_q, mode_d;

    logic [NUM_LEVELS:0]           carry;
    logic [NUM_LEVELS-1:0]         at_limit;
    logic                          run;
    logic                          advance;
    logic                          terminal;
    logic                          accept;
    logic                          clear;

    assign run      = (state_q == RUN);
    assign advance  = run & enable & ~abort & rst_n;
    assign accept   = start & ~abort & ((state_q == IDLE) | (state_q == DONE));
    // Indices are only live in RUN; everywhere else they sit at zero.
    assign clear    = ~run | abort;
    assign carry[0] = advance;
    assign terminal = carry[NUM_LEVELS];

    for (genvar g = 0; g < NUM_LEVELS; g++) begin : g_level
        counter_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .limit   (limit_q[g*WIDTH +: WIDTH]),
            .carry_in(carry[g]),
            .clear   (clear),
            .value   (count_out[g*WIDTH +: WIDTH]),
            .at_limit(at_limit[g])
        );
        assign carry[g+1] = carry[g] & at_limit[g];
    end

    assign level_wrap = carry[NUM_LEVELS:1];
    assign valid      = run;
    assign busy       = run;
    assign done       = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        limit_d = limit_q;
        mode_d  = mode_q;
        if (accept) begin
            limit_d = cfg_limit;
            mode_d  = cfg_mode;
        end
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (accept) state_d = RUN;
                RUN: begin
                    if (terminal && mode_q == MODE_ONESHOT) begin
                        state_d = DONE;
                    end
                end
                DONE: state_d = accept ? RUN : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            limit_q <= '0;
            mode_q  <= MODE_ONESHOT;
        end else begin
            state_q <= state_d;
            limit_q <= limit_d;
            mode_q  <= mode_d;
        end
    end

endmodule

// File: tb/tb_nested_loop_counter.sv
// Scoreboard bench for nested_loop_counter using a mixed-radix
// iteration model of the expected loop indices.
module tb_nested_loop_counter;

    localparam int NL = 3;
    localparam int W  = 4;
    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_DONE = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              enable = 1'b0;
    logic              abort = 1'b0;
    logic              cfg_mode = 1'b0;
    logic [NL*W-1:0]   cfg_limit = '0;
    logic [NL*W-1:0]   count_out;
    logic              valid;
    logic [NL-1:0]     level_wrap;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    nested_loop_counter #(
        .NUM_LEVELS(NL),
        .WIDTH     (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .enable    (enable),
        .abort     (abort),
        .cfg_mode  (cfg_mode),
        .cfg_limit (cfg_limit),
        .count_out (count_out),
        .valid     (valid),
        .level_wrap(level_wrap),
        .busy      (busy),
        .done      (done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: linear iteration index k over a mixed-radix space.
    int   m_st = S_IDLE;
    int   m_k = 0;
    int   m_lim[NL];
    int   m_mode = 0;
    bit   armed = 1'b0;
    int   vcnt = 0;
    int   acnt = 0;
    logic [NL*W+2:0] sbq[$];

    function automatic int rad(int i);
        return m_lim[i] + 1;
    endfunction

    function automatic logic [NL*W-1:0] digits(int k);
        int d0, d1, d2;
        d0 = k % rad(0);
        d1 = (k / rad(0)) % rad(1);
        d2 = (k / (rad(0) * rad(1))) % rad(2);
        return {4'(d2), 4'(d1), 4'(d0)};
    endfunction

    function automatic logic [NL-1:0] exp_wrap(bit adv);
        logic [NL-1:0] w;
        w = '0;
        if (adv) begin
            w[0] = ((m_k + 1) % rad(0)) == 0;
            w[1] = ((m_k + 1) % (rad(0) * rad(1))) == 0;
            w[2] = ((m_k + 1) % (rad(0) * rad(1) * rad(2))) == 0;
        end
        return w;
    endfunction

    task automatic latch_cfg(input bit md, input logic [NL*W-1:0] lim);
        logic [NL*W-1:0] l;
        l = lim;
        for (int i = 0; i < NL; i++) m_lim[i] = int'(l[i*W +: W]);
        m_mode = int'(md);
        m_st = S_RUN;
        m_k = 0;
    endtask

    task automatic pop_check();
        logic [NL*W+2:0] e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("regs", {19'd0, count_out, valid, busy, done}, {19'd0, e});
        end
    endtask

    task automatic step(input bit rs, input bit st, input bit en,
                        input bit ab, input bit md,
                        input logic [NL*W-1:0] lim);
        bit adv;
        logic [NL*W-1:0] ec;
        @(negedge clk);
        pop_check();
        rst_n = rs; start = st; enable = en;
        abort = ab; cfg_mode = md; cfg_limit = lim;
        #1;
        adv = rs && !ab && en && (m_st == S_RUN);
        if (armed) check("wrap", {29'd0, level_wrap}, {29'd0, exp_wrap(adv)});
        if (valid === 1'b1) vcnt++;
        if (valid === 1'b1 && en && !ab && rs) acnt++;
        if (!rs) begin
            m_st = S_IDLE; m_k = 0; m_mode = 0;
            for (int i = 0; i < NL; i++) m_lim[i] = 0;
            armed = 1'b1;
        end else if (ab) begin
            m_st = S_IDLE; m_k = 0;
        end else begin
            case (m_st)
                S_IDLE: if (st) latch_cfg(md, lim);
                S_RUN: begin
                    if (en) begin
                        if (m_k == rad(0) * rad(1) * rad(2) - 1) begin
                            m_k = 0;
                            if (m_mode == 0) m_st = S_DONE;
                        end else begin
                            m_k++;
                        end
                    end
                end
                default: begin
                    if (st) latch_cfg(md, lim);
                    else m_st = S_IDLE;
                end
            endcase
        end
        ec = (m_st == S_RUN) ? digits(m_k) : '0;
        sbq.push_back({ec, m_st == S_RUN, m_st == S_RUN, m_st == S_DONE});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 12'h000);
    endtask

    initial begin
        for (int i = 0; i < NL; i++) m_lim[i] = 0;

        // Reset, then interrupt a run at index (1,0,2) with a 2-cycle reset
        step(0, 0, 0, 0, 0, 12'h000);
        step(0, 0, 0, 0, 0, 12'h000);
        idle(1);
        step(1, 1, 0, 0, 0, 12'h213);
        for (int i = 0; i < 10; i++) step(1, 0, 1, 0, 0, 12'h213);
        step(0, 0, 1, 0, 0, 12'h213);
        step(0, 0, 1, 0, 0, 12'h213);
        idle(1);

        // One-shot (2,1,3), enable held high
        vcnt = 0;
        step(1, 1, 0, 0, 0, 12'h213);
        for (int i = 0; i < 24; i++) step(1, 0, 1, 0, 0, 12'h213);
        idle(3);
        check("valid_cycles", 32'(vcnt), 32'd24);

        // Stall: enable toggles every cycle
        acnt = 0;
        step(1, 1, 0, 0, 0, 12'h213);
        for (int i = 0; i < 48; i++) step(1, 0, (i % 2) == 0, 0, 0, 12'h213);
        idle(3);
        check("stall_advances", 32'(acnt), 32'd24);

        // Wrap mode (1,1,1); cfg change mid-run ignored; then abort
        step(1, 1, 0, 0, 1, 12'h111);
        for (int i = 0; i < 8; i++) step(1, 0, 1, 0, 1, 12'h111);
        for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 0, 12'h333);
        step(1, 0, 1, 1, 0, 12'h333);
        idle(2);

        // All-zero limits: a single iteration
        vcnt = 0;
        step(1, 1, 0, 0, 0, 12'h000);
        step(1, 0, 1, 0, 0, 12'h000);
        idle(2);
        check("zero_lim_valid", 32'(vcnt), 32'd1);

        // (0,2,0): level 0 wraps on every advance
        step(1, 1, 0, 0, 0, 12'h020);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0, 12'h020);
        idle(2);

        // Back-to-back start during DONE, then abort in DONE
        step(1, 1, 0, 0, 0, 12'h001);
        step(1, 0, 1, 0, 0, 12'h001);
        step(1, 0, 1, 0, 0, 12'h001);
        step(1, 1, 0, 0, 0, 12'h010);
        step(1, 0, 1, 0, 0, 12'h010);
        step(1, 0, 1, 0, 0, 12'h010);
        step(1, 1, 0, 1, 0, 12'h010);
        idle(2);

        // start together with abort in IDLE
        step(1, 1, 0, 1, 0, 12'h213);
        step(1, 0, 1, 0, 0, 12'h213);
        idle(2);

        @(negedge clk);
        pop_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nested_loop_counter.md
# nested_loop_counter

Parametrised multi-level loop counter that generalises the team's 4-bit enable counter into NUM_LEVELS cascaded stages, each with a programmable terminal value. It generates nested loop indices (kernel column, kernel row, channel) for the convolution address generators. It has a start/busy/done handshake, a stall input, and one-shot and free-running wrap modes.

## Interface
- NUM_LEVELS, default 3: number of cascaded levels. Level 0 is innermost.
- WIDTH, default 4: bits per level.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset. Sampled on clk rising edge only.
- start  in  1  begin a loop sequence. Accepted in IDLE or DONE.
- enable  in  1  advance the index this cycle. Only meaningful in RUN.
- abort  in  1  terminate the sequence. Highest priority after reset.
- cfg_mode  in  1  0 = one-shot, 1 = free-running wrap.
- cfg_limit  in  NUM_LEVELS*WIDTH  terminal value per level. Level i occupies [i*WIDTH +: WIDTH].
- count_out  out  NUM_LEVELS*WIDTH  current index, same packing as cfg_limit.
- valid  out  1  count_out is a live index. High exactly in RUN.
- level_wrap  out  NUM_LEVELS  bit i is high when level i wraps on this cycle's advance.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse in DONE.

## Operation
- States:
  - IDLE: reset state.
  - RUN
  - DONE: transient, lasts one cycle.
- Reset (rst_n=0 at a posedge) forces, from any state or mid-sequence:
  - state IDLE
  - count_out, latched limits and latched mode = 0
  - valid, busy, done, level_wrap = 0
- IDLE, start=1, abort=0 → RUN. Latch cfg_limit and cfg_mode. count_out = 0.
- Latched configuration is frozen for the whole sequence. cfg_* changes during RUN are ignored.
- Advance = RUN & enable & ~abort.
  - Level 0 increments on every advance.
  - Level i increments only when levels 0..i-1 are all at their limits.
  - A level at its limit that receives a carry returns to 0.
- level_wrap[i] = advance & (levels 0..i all at limit). Combinational (Mealy), aligned with the index being consumed.
- Terminal index = every level at its limit. An advance on it does the following:
  - cfg_mode=0: go to DONE. count_out returns to 0.
  - cfg_mode=1: all levels return to 0, level_wrap = all ones, stay in RUN indefinitely.
- DONE → IDLE next cycle. If start=1 in DONE → RUN directly (back-to-back), relatching cfg.
- abort in RUN or DONE → IDLE next cycle. count_out = 0, no done pulse.
- abort together with start in IDLE → stays IDLE.
- start in RUN is ignored. enable outside RUN is ignored.
- Limit 0 on a level: that level stays at 0 and carries on every advance it receives.
- Iterations per one-shot sequence = product of (limit_i + 1). All-zero limits give one iteration.

## Timing
- count_out, valid, busy and done are registered.
- start accepted at edge N → valid=1 and count_out=0 from edge N onward.
- Each advance updates count_out at the following edge. With enable=0, count_out holds.
- The last advance at edge M → done=1 and busy=0 during cycle M..M+1. done drops at M+1 unless back-to-back start re-enters RUN.
- Stall-free throughput: one index per cycle. Zero bubbles between wrap-mode passes.
- Priority per edge: rst_n, then abort, then start/advance.

## Structure
- Shared package cnn_counter_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - MODE_ONESHOT / MODE_WRAP constants
  - default NUM_LEVELS/WIDTH constants reused by the address generators
- Sub-module counter_stage: one WIDTH-bit level with inputs limit, carry_in, clear, and outputs value, at_limit. Instantiated NUM_LEVELS times with a generate loop.
- Top level: FSM, configuration latch, carry chain, output packing.

## Test plan
Default parameters (NUM_LEVELS=3, WIDTH=4); limits are written as (L2,L1,L0).
- Reset: rst_n=0 for 2 cycles at index (1,0,2) mid-RUN → at next posedge count_out=0, valid=busy=done=0, level_wrap=0. After release, start works normally.
- One-shot, limits (2,1,3), enable held high → sequence (0,0,0),(0,0,1)…(2,1,3), exactly 24 valid cycles. level_wrap[0] every 4th advance, level_wrap[1] every 8th. done is a single pulse one cycle after (2,1,3), then IDLE.
- Stall: same config, enable toggled 1,0,1,0 → count_out holds on every enable=0 cycle. Still exactly 24 advances, then done. No index is skipped or repeated.
- Wrap mode, limits (1,1,1), enable high → after 8 advances returns to (0,0,0) with level_wrap=3'b111 on the 8th, busy stays 1. cfg_limit changed to (3,3,3) mid-run → ignored. abort → IDLE next cycle, no done.
- Edges:
  - limits (0,0,0) one-shot → one valid cycle at index 0, then done.
  - limits (0,2,0) → level_wrap[0] on every advance.
  - start asserted during DONE → RUN next cycle with count 0.
  - start+abort together in IDLE → stays IDLE.
